// File: rtl/uart_tx_ctrl.sv
// uart_tx_ctrl: transmit sequencer that paces the serial line on the baud
// generator's tx_bpsclk strobes. It accepts one byte per frame over a
// valid/ready handshake and sends start, data (LSB first), optional parity
// and one or two stop bits. A watchdog aborts the frame if strobes stop.
//
// Build option: define UART_TX_PARITY_EN to include the parity bit (PAR state,
// cfg_par_en / cfg_par_odd). When it is undefined, frames carry no parity and
// the cfg_par inputs are ignored.
module uart_tx_ctrl #(
    parameter int STROBE_TO = 20000,
    parameter int TO_W      = 15
) (
    input  logic       clk26m,
    input  logic       rstn,
    input  logic       cfg_en,
    input  logic [1:0] cfg_dlen,
    input  logic       cfg_stop,
    input  logic       cfg_par_en,
    input  logic       cfg_par_odd,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic       tx_bpsclk,
    output logic       tx_bps_en,
    output logic       txd,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       tx_err
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_WAIT  = 3'd1;
    localparam logic [2:0] S_START = 3'd2;
    localparam logic [2:0] S_DATA  = 3'd3;
    localparam logic [2:0] S_PAR   = 3'd4;
    localparam logic [2:0] S_STOP  = 3'd5;

    logic [2:0]      state;
    logic [7:0]      data_q;
    logic [1:0]      dlen_q;
    logic            stop_q;
    logic [2:0]      bit_cnt;
    logic            stop_cnt;
    logic [TO_W-1:0] wd;

    logic            accept;
    logic [2:0]      last_bit;
    logic [2:0]      next_bit;
    logic            wd_expire;

`ifdef UART_TX_PARITY_EN
    logic            par_en_q;
    logic            par_odd_q;
    logic [7:0]      par_mask;
    logic            par_bit;
`else
    // Parity configuration has no function in this build; the name keeps
    // the intentionally ignored inputs from looking like a wiring mistake.
    logic            unused_par;
    assign unused_par = cfg_par_en ^ cfg_par_odd;
`endif

    // Reset is folded in so the handshake reads 0 while rstn is held low.
    assign tx_ready  = (state == S_IDLE) & cfg_en & rstn;
    assign accept    = tx_valid & tx_ready;
    assign tx_busy   = (state != S_IDLE);
    assign last_bit  = {1'b0, dlen_q} + 3'd4;
    assign next_bit  = bit_cnt + 3'd1;
    // A strobe on the expiry cycle wins, so expiry requires no strobe.
    assign wd_expire = tx_bps_en & ~tx_bpsclk & (wd >= TO_W'(STROBE_TO - 1));

`ifdef UART_TX_PARITY_EN
    // Parity covers only the latched data length; unused high bits are masked.
    always_comb begin
        par_mask = 8'hFF;
        case (dlen_q)
            2'd0:    par_mask = 8'h1F;
            2'd1:    par_mask = 8'h3F;
            2'd2:    par_mask = 8'h7F;
            default: par_mask = 8'hFF;
        endcase
        par_bit = (^(data_q & par_mask)) ^ par_odd_q;
    end
`endif

    // Watchdog counts cycles between strobes while the generator runs and saturates.
    always_ff @(posedge clk26m) begin
        if (!rstn) begin
            wd <= '0;
        end else if (!tx_bps_en || tx_bpsclk) begin
            wd <= '0;
        end else if (wd < TO_W'(STROBE_TO)) begin
            wd <= wd + 1'b1;
        end
    end

    // Frame sequencer: accept in IDLE, then one bit step per strobe.
    always_ff @(posedge clk26m) begin
        if (!rstn) begin
            state     <= S_IDLE;
            txd       <= 1'b1;
            tx_bps_en <= 1'b0;
            tx_done   <= 1'b0;
            tx_err    <= 1'b0;
            data_q    <= '0;
            dlen_q    <= '0;
            stop_q    <= 1'b0;
            bit_cnt   <= '0;
            stop_cnt  <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_en_q  <= 1'b0;
            par_odd_q <= 1'b0;
`endif
        end else begin
            tx_done <= 1'b0;
            tx_err  <= 1'b0;
            if (wd_expire) begin
                state     <= S_IDLE;
                txd       <= 1'b1;
                tx_bps_en <= 1'b0;
                tx_err    <= 1'b1;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (accept) begin
                            data_q    <= tx_data;
                            dlen_q    <= cfg_dlen;
                            stop_q    <= cfg_stop;
`ifdef UART_TX_PARITY_EN
                            par_en_q  <= cfg_par_en;
                            par_odd_q <= cfg_par_odd;
`endif
                            tx_bps_en <= 1'b1;
                            state     <= S_WAIT;
                        end
                    end
                    S_WAIT: begin
                        if (tx_bpsclk) begin
                            txd   <= 1'b0;
                            state <= S_START;
                        end
                    end
                    S_START: begin
                        if (tx_bpsclk) begin
                            txd     <= data_q[0];
                            bit_cnt <= '0;
                            state   <= S_DATA;
                        end
                    end
                    S_DATA: begin
                        if (tx_bpsclk) begin
                            if (bit_cnt != last_bit) begin
                                bit_cnt <= next_bit;
                                txd     <= data_q[next_bit];
                            end else begin
`ifdef UART_TX_PARITY_EN
                                if (par_en_q) begin
                                    txd   <= par_bit;
                                    state <= S_PAR;
                                end else begin
                                    txd      <= 1'b1;
                                    stop_cnt <= 1'b0;
                                    state    <= S_STOP;
                                end
`else
                                txd      <= 1'b1;
                                stop_cnt <= 1'b0;
                                state    <= S_STOP;
`endif
                            end
                        end
                    end
`ifdef UART_TX_PARITY_EN
                    S_PAR: begin
                        if (tx_bpsclk) begin
                            txd      <= 1'b1;
                            stop_cnt <= 1'b0;
                            state    <= S_STOP;
                        end
                    end
`endif
                    S_STOP: begin
                        if (tx_bpsclk) begin
                            if (stop_cnt < stop_q) begin
                                stop_cnt <= 1'b1;
                            end else begin
                                state     <= S_IDLE;
                                tx_bps_en <= 1'b0;
                                tx_done   <= 1'b1;
                            end
                        end
                    end
                    default: begin
                        state     <= S_IDLE;
                        txd       <= 1'b1;
                        tx_bps_en <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// tb_uart_tx_ctrl: directed self-checking bench for uart_tx_ctrl. Strobes are
// issued every 10 clocks; txd, tx_done and tx_bps_en are sampled 1ns after
// each clock edge and compared with values derived from the frame format.
module tb_uart_tx_ctrl;

    localparam int STROBE_TO = 20000;

    logic       clk26m = 1'b0;
    logic       rstn = 1'b0;
    logic       cfg_en = 1'b0;
    logic [1:0] cfg_dlen = 2'd3;
    logic       cfg_stop = 1'b0;
    logic       cfg_par_en = 1'b0;
    logic       cfg_par_odd = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_bpsclk = 1'b0;
    logic       tx_ready;
    logic       tx_bps_en;
    logic       txd;
    logic       tx_busy;
    logic       tx_done;
    logic       tx_err;

    int compare_count = 0;
    int mismatch_count = 0;

    uart_tx_ctrl #(.STROBE_TO(STROBE_TO), .TO_W(15)) dut (
        .clk26m(clk26m), .rstn(rstn), .cfg_en(cfg_en), .cfg_dlen(cfg_dlen),
        .cfg_stop(cfg_stop), .cfg_par_en(cfg_par_en), .cfg_par_odd(cfg_par_odd),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .tx_bpsclk(tx_bpsclk), .tx_bps_en(tx_bps_en), .txd(txd),
        .tx_busy(tx_busy), .tx_done(tx_done), .tx_err(tx_err)
    );

    // 26 MHz-style free-running clock (period is arbitrary for the bench).
    always #5 clk26m = ~clk26m;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compare_count++;
        if (observed !== expected) begin
            mismatch_count++;
            $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk26m);
        #1;
    endtask

    task automatic strobe();
        tx_bpsclk = 1'b0;
        repeat (9) tick();
        tx_bpsclk = 1'b1;
        tick();
        tx_bpsclk = 1'b0;
    endtask

    task automatic applyStimulus(input logic [7:0] data, input string tag);
        tx_data  = data;
        tx_valid = 1'b1;
        #1;
        checkOutput({tag, " ready"}, tx_ready, 1'b1);
        tick();
        tx_valid = 1'b0;
        checkOutput({tag, " busy_after_accept"}, tx_busy, 1'b1);
        checkOutput({tag, " bps_en_after_accept"}, tx_bps_en, 1'b1);
        checkOutput({tag, " txd_idle_level"}, txd, 1'b1);
    endtask

    task automatic strobeFrame(input logic [7:0] data, input int nbits, input bit stop2,
                               input bit par_on, input bit par_odd, input string tag);
        int   n;
        logic par;
        logic exp_bit;
        par = 1'b0;
        for (int i = 0; i < nbits; i++) par = par ^ data[i];
        if (par_odd) par = ~par;
        n = 1 + nbits + (par_on ? 1 : 0) + 1 + (stop2 ? 1 : 0) + 1;
        for (int k = 1; k <= n; k++) begin
            strobe();
            if (k == 1) exp_bit = 1'b0;
            else if (k <= nbits + 1) exp_bit = data[k-2];
            else if (par_on && k == nbits + 2) exp_bit = par;
            else exp_bit = 1'b1;
            checkOutput($sformatf("%s txd@%0d", tag, k), txd, exp_bit);
            checkOutput($sformatf("%s done@%0d", tag, k), tx_done, (k == n));
            checkOutput($sformatf("%s bps_en@%0d", tag, k), tx_bps_en, (k != n));
            checkOutput($sformatf("%s busy@%0d", tag, k), tx_busy, (k != n));
        end
    endtask

    initial begin
        int waited;

        // Reset state.
        rstn   = 1'b0;
        cfg_en = 1'b1;
        repeat (2) tick();
        checkOutput("rst txd", txd, 1'b1);
        checkOutput("rst bps_en", tx_bps_en, 1'b0);
        checkOutput("rst busy", tx_busy, 1'b0);
        checkOutput("rst ready", tx_ready, 1'b0);
        checkOutput("rst done", tx_done, 1'b0);
        checkOutput("rst err", tx_err, 1'b0);
        rstn = 1'b1;
        tick();

        // 8N1, 0xA5: 0,1,0,1,0,0,1,0,1,1 then done on strobe 11.
        cfg_dlen = 2'd3;
        cfg_stop = 1'b0;
        applyStimulus(8'hA5, "t1");
        strobeFrame(8'hA5, 8, 1'b0, 1'b0, 1'b0, "t1");
        tick();
        checkOutput("t1 gap bps_en", tx_bps_en, 1'b0);
        checkOutput("t1 done_cleared", tx_done, 1'b0);

        // 5 data bits, two stops; config changes after accept must be ignored.
        cfg_dlen = 2'd0;
        cfg_stop = 1'b1;
        applyStimulus(8'hFF, "t2");
        cfg_dlen = 2'd3;
        cfg_stop = 1'b0;
        strobeFrame(8'hFF, 5, 1'b1, 1'b0, 1'b0, "t2");
        tick();

`ifdef UART_TX_PARITY_EN
        // 8O1 and 8E1 with 0x03: parity bit 1 then 0, done on strobe 12.
        cfg_par_en  = 1'b1;
        cfg_par_odd = 1'b1;
        applyStimulus(8'h03, "t3odd");
        strobeFrame(8'h03, 8, 1'b0, 1'b1, 1'b1, "t3odd");
        tick();
        cfg_par_odd = 1'b0;
        applyStimulus(8'h03, "t3even");
        strobeFrame(8'h03, 8, 1'b0, 1'b1, 1'b0, "t3even");
        tick();
        cfg_par_en = 1'b0;
`endif

        // Watchdog: strobes stop after the start bit.
        applyStimulus(8'h5A, "t4");
        strobe();
        checkOutput("t4 start_bit", txd, 1'b0);
        waited = 0;
        for (int k = 1; k <= STROBE_TO + 20; k++) begin
            tick();
            if (tx_err) begin
                waited = k;
                break;
            end
        end
        checkOutput("t4 wd_latency", waited, STROBE_TO);
        checkOutput("t4 txd", txd, 1'b1);
        checkOutput("t4 busy", tx_busy, 1'b0);
        checkOutput("t4 bps_en", tx_bps_en, 1'b0);
        checkOutput("t4 no_done", tx_done, 1'b0);
        tick();
        checkOutput("t4 err_pulse_len", tx_err, 1'b0);
        checkOutput("t4 txd_after", txd, 1'b1);

        // cfg_en dropped mid-frame with tx_valid held high.
        tx_data  = 8'h3C;
        tx_valid = 1'b1;
        #1;
        checkOutput("t5 ready", tx_ready, 1'b1);
        tick();
        tx_data = 8'hC3;
        cfg_en  = 1'b0;
        #1;
        checkOutput("t5 ready_busy", tx_ready, 1'b0);
        strobeFrame(8'h3C, 8, 1'b0, 1'b0, 1'b0, "t5a");
        repeat (3) tick();
        checkOutput("t5 ready_disabled", tx_ready, 1'b0);
        checkOutput("t5 no_accept", tx_busy, 1'b0);
        cfg_en = 1'b1;
        #1;
        checkOutput("t5 ready_reenabled", tx_ready, 1'b1);
        tick();
        checkOutput("t5 accept_busy", tx_busy, 1'b1);
        tx_data = 8'h96;
        strobeFrame(8'hC3, 8, 1'b0, 1'b0, 1'b0, "t5b");
        checkOutput("t5 ready_at_idle", tx_ready, 1'b1);
        tick();
        tx_valid = 1'b0;
        checkOutput("t5 back_to_back", tx_busy, 1'b1);
        strobeFrame(8'h96, 8, 1'b0, 1'b0, 1'b0, "t5c");
        tick();

        // Reset pulse in the middle of the data bits.
        applyStimulus(8'hF0, "t6");
        repeat (3) strobe();
        checkOutput("t6 in_data", tx_busy, 1'b1);
        rstn = 1'b0;
        tick();
        checkOutput("t6 txd", txd, 1'b1);
        checkOutput("t6 bps_en", tx_bps_en, 1'b0);
        checkOutput("t6 busy", tx_busy, 1'b0);
        checkOutput("t6 ready", tx_ready, 1'b0);
        checkOutput("t6 done", tx_done, 1'b0);
        checkOutput("t6 err", tx_err, 1'b0);
        rstn = 1'b1;
        tick();
        applyStimulus(8'h81, "t6b");
        strobeFrame(8'h81, 8, 1'b0, 1'b0, 1'b0, "t6b");
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_count, mismatch_count);
        $finish;
    end

endmodule

// File: doc/uart_tx_ctrl.md
Name: uart_tx_ctrl

Overview:
Transmit sequencer for the UART baud generator. It accepts one byte at a time from the APB-side TX buffer through a valid/ready handshake, and drives the generator's tx_bps_en. On each tx_bpsclk strobe it steps the serial line through start, data, optional parity and stop bits. A watchdog aborts the frame if strobes stop arriving.

Parameters:
STROBE_TO, 20000, clk26m cycles allowed between consecutive tx_bpsclk strobes while tx_bps_en=1 before abort; must exceed the largest bit period (16384).
TO_W, 15, watchdog counter width; must satisfy 2^TO_W > STROBE_TO.

Ports:
clk26m  input  1  function clock
rstn  input  1  function reset, synchronous, active-low
cfg_en  input  1  transmitter enable
cfg_dlen  input  2  data length: 0=5, 1=6, 2=7, 3=8 bits
cfg_stop  input  1  0=one stop bit, 1=two stop bits
cfg_par_en  input  1  parity enable (used only with UART_TX_PARITY_EN)
cfg_par_odd  input  1  1=odd, 0=even parity (used only with UART_TX_PARITY_EN)
tx_data  input  8  byte to send, LSB first; bits above the data length are ignored
tx_valid  input  1  tx_data valid
tx_ready  output  1  byte accepted on tx_valid & tx_ready
tx_bpsclk  input  1  one-cycle bit strobe from the baud generator
tx_bps_en  output  1  baud generator enable
txd  output  1  serial output
tx_busy  output  1  frame in progress (state != IDLE)
tx_done  output  1  one-cycle pulse at normal frame end
tx_err  output  1  one-cycle pulse on watchdog abort

Behaviour:
- Clock and reset: clk26m is the only clock. Reset is synchronous, active-low on rstn.
- Reset values: state=IDLE, txd=1, tx_bps_en=0, tx_ready=0, tx_busy=0, tx_done=0, tx_err=0, watchdog=0. All outputs are registered except tx_ready and tx_busy.
- tx_ready = (state==IDLE) & cfg_en.
- Latching: on accept, latch tx_data, cfg_dlen, cfg_stop, cfg_par_en and cfg_par_odd. Config changes mid-frame have no effect.
- FSM, advancing only on cycles where tx_bpsclk=1 unless noted:
  IDLE: on accept -> WAIT; tx_bps_en<=1 in the same edge; txd stays 1.
  WAIT: strobe -> txd<=0, go to START (start bit begins).
  START: strobe -> txd<=d[0], bit_cnt<=0, go to DATA.
  DATA: strobe with bit_cnt < len-1 -> bit_cnt++, txd<=d[bit_cnt+1]. Strobe with bit_cnt==len-1 -> txd<=parity and go to PAR if parity is active; otherwise txd<=1, stop_cnt<=0, go to STOP.
  PAR: strobe -> txd<=1, stop_cnt<=0, go to STOP.
  STOP: strobe with stop_cnt < cfg_stop -> stop_cnt++. Strobe otherwise -> go to IDLE, tx_bps_en<=0, tx_done<=1 for one cycle.
- Frame timing: an 8N1 frame spans 11 strobes from accept to IDLE. Each extra data bit, the parity bit and a second stop bit each add one strobe.
- Inter-frame gap: tx_bps_en drops for at least one cycle between frames, so the generator counter restarts. A byte presented while the FSM is returning to IDLE is accepted on the first IDLE cycle.
- Parity: even = XOR of the len data bits; odd = inverse of that.
- cfg_en deasserted mid-frame: the frame completes normally; no new accept occurs until cfg_en returns.
- Watchdog:
  - Clears on every strobe and whenever tx_bps_en=0; otherwise increments.
  - Reaching STROBE_TO forces IDLE, txd<=1, tx_bps_en<=0 and a one-cycle tx_err pulse; tx_done is not asserted.
  - The counter saturates and never wraps.
- Strobe ignored in IDLE.
- Strobe and watchdog expiry on the same cycle: the strobe wins and the watchdog clears.
- rstn low mid-frame: return to the reset state at the next edge; txd=1 on the following cycle.

Optional Feature:
UART_TX_PARITY_EN.
- Defined: the PAR state, cfg_par_en and cfg_par_odd are implemented as described.
- Undefined: PAR and the parity logic are absent, and both cfg_par inputs are left unconnected. Frames are always N (no parity).

Test Plan:
- 8N1, tx_data=8'hA5, strobe every 10 cycles: txd sequence 0,1,0,1,0,0,1,0,1,1; tx_done pulses on strobe 11 after accept; tx_bps_en low for ≥1 cycle afterward.
- cfg_dlen=0, cfg_stop=1, tx_data=8'hFF: 5 data bits of 1 then two stop bits; tx_done on strobe 9.
- UART_TX_PARITY_EN defined, 8 bits, odd parity, tx_data=8'h03: parity bit=1; even parity gives 0; tx_done on strobe 12.
- Strobes stop after the start bit: tx_err pulses exactly STROBE_TO cycles after the last strobe; txd=1 and tx_busy=0 on the next cycle.
- tx_valid held high with cfg_en toggled low mid-frame: current frame completes; tx_ready stays 0 until cfg_en=1; second byte accepted on the first eligible IDLE cycle.
- rstn low for one cycle during DATA: all outputs at reset values on the next cycle, txd=1; a new frame is accepted afterward.
